// File: rtl/des_decrypt_iter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : des_decrypt_iter_pkg
//  Description : DES permutation tables, S-boxes, decrypt shift schedule,
//                FSM state codes and bit-permutation helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package des_decrypt_iter_pkg;

   localparam logic [1:0] c_stIdle  = 2'd0;
   localparam logic [1:0] c_stRound = 2'd1;
   localparam logic [1:0] c_stDone  = 2'd2;

   // All tables use DES numbering: entry n names input bit n, bit 1 = MSB.
   localparam int c_ip [64] = '{
      58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
      62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
      57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
      61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

   localparam int c_fp [64] = '{
      40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
      38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
      36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
      34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

   localparam int c_e [48] = '{
      32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
       8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
      16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
      24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

   localparam int c_p [32] = '{
      16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
       2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

   localparam int c_pc1 [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

   localparam int c_pc2 [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

   // Right-rotate applied before each decrypt round; round 1 uses C0/D0 as-is.
   localparam int c_shiftDec [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   localparam int c_sbox [8][4][16] = '{
      '{'{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7}, '{ 0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8},
        '{ 4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0}, '{15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13}},
      '{'{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10}, '{ 3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5},
        '{ 0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15}, '{13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9}},
      '{'{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8}, '{13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1},
        '{13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7}, '{ 1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12}},
      '{'{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15}, '{13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9},
        '{10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4}, '{ 3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14}},
      '{'{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9}, '{14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6},
        '{ 4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14}, '{11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3}},
      '{'{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11}, '{10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8},
        '{ 9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6}, '{ 4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13}},
      '{'{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1}, '{13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6},
        '{ 1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2}, '{ 6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12}},
      '{'{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7}, '{ 1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2},
        '{ 7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8}, '{ 2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}}};

   function automatic logic [63:0] ipPerm(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - c_ip[6'(i)])];
      return y;
   endfunction

   function automatic logic [63:0] fpPerm(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - c_fp[6'(i)])];
      return y;
   endfunction

   function automatic logic [47:0] eExpand(input logic [31:0] x);
      logic [47:0] y;
      y = '0;
      for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - c_e[6'(i)])];
      return y;
   endfunction

   function automatic logic [31:0] pPerm(input logic [31:0] x);
      logic [31:0] y;
      y = '0;
      for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - c_p[5'(i)])];
      return y;
   endfunction

   function automatic logic [55:0] pc1Perm(input logic [63:0] x);
      logic [55:0] y;
      y = '0;
      for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - c_pc1[6'(i)])];
      return y;
   endfunction

   function automatic logic [47:0] pc2Perm(input logic [55:0] x);
      logic [47:0] y;
      y = '0;
      for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - c_pc2[6'(i)])];
      return y;
   endfunction

   function automatic logic [27:0] rotR28(input logic [27:0] x, input logic [1:0] n);
      case (n)
         2'd1:    return {x[0], x[27:1]};
         2'd2:    return {x[1:0], x[27:2]};
         default: return x;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/des_decrypt_iter_if.sv
`default_nettype none
// ============================================================================
//  Module      : des_decrypt_iter_if
//  Description : Input/output valid-ready handshake bundle of the DES core.
//  Revision    : 1.0 - initial release
// ============================================================================
interface des_decrypt_iter_if;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] cipher_text;
   logic [63:0] key;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] plain_text;
   logic        busy;

   modport master (
      output in_valid, cipher_text, key, out_ready,
      input  in_ready, out_valid, plain_text, busy
   );

   modport slave (
      input  in_valid, cipher_text, key, out_ready,
      output in_ready, out_valid, plain_text, busy
   );
endinterface
`default_nettype wire

// File: rtl/des_decrypt_iter_round_f.sv
`default_nettype none
// ============================================================================
//  Module      : des_decrypt_iter_round_f
//  Description : Combinational DES round function f(R, K) = P(S(E(R) ^ K)).
//  Revision    : 1.0 - initial release
// ============================================================================
module des_decrypt_iter_round_f
   import des_decrypt_iter_pkg::*;
(
   input  logic [31:0] i_r,
   input  logic [47:0] i_k,
   output logic [31:0] o_f
);

   logic [47:0] w_x;
   logic [31:0] w_sOut;

   assign w_x = eExpand(i_r) ^ i_k;

   // Row is the outer bit pair {b1,b6}, column the inner four bits.
   for (genvar gs = 0; gs < 8; gs++) begin : g_sbox
      logic [5:0] w_grp;
      assign w_grp = w_x[47 - 6*gs -: 6];
      assign w_sOut[31 - 4*gs -: 4] = 4'(c_sbox[gs][{w_grp[5], w_grp[0]}][w_grp[4:1]]);
   end

   assign o_f = pPerm(w_sOut);

endmodule
`default_nettype wire

// File: rtl/des_decrypt_iter.sv
`default_nettype none
// ============================================================================
//  Module      : des_decrypt_iter
//  Description : Iterative DES decryption core, UNROLL rounds per clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module des_decrypt_iter
   import des_decrypt_iter_pkg::*;
#(
   parameter int UNROLL = 1
)(
   input  logic              clk,
   input  logic              rst_n,
   des_decrypt_iter_if.slave bus
);

   if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8 && UNROLL != 16) begin : g_badUnroll
      $error("des_decrypt_iter: UNROLL must be 1, 2, 4, 8 or 16");
   end

   logic [1:0]  r_state;
   logic [4:0]  r_roundCnt;
   logic [31:0] r_left;
   logic [31:0] r_right;
   logic [27:0] r_c;
   logic [27:0] r_d;
   logic [63:0] r_plainText;

   logic [31:0] w_l [0:UNROLL];
   logic [31:0] w_r [0:UNROLL];
   logic [27:0] w_c [0:UNROLL];
   logic [27:0] w_d [0:UNROLL];
   logic [4:0]  w_nextCnt;

   assign w_l[0]    = r_left;
   assign w_r[0]    = r_right;
   assign w_c[0]    = r_c;
   assign w_d[0]    = r_d;
   assign w_nextCnt = r_roundCnt + 5'(UNROLL);

   // C/D registers hold the halves already rotated for the last applied round.
   for (genvar gi = 0; gi < UNROLL; gi++) begin : g_round
      logic [1:0]  w_sh;
      logic [27:0] w_cRot;
      logic [27:0] w_dRot;
      logic [47:0] w_subKey;
      logic [31:0] w_f;

      assign w_sh     = 2'(c_shiftDec[r_roundCnt[3:0] + 4'(gi)]);
      assign w_cRot   = rotR28(w_c[gi], w_sh);
      assign w_dRot   = rotR28(w_d[gi], w_sh);
      assign w_subKey = pc2Perm({w_cRot, w_dRot});

      des_decrypt_iter_round_f u_roundF (
         .i_r (w_r[gi]),
         .i_k (w_subKey),
         .o_f (w_f)
      );

      assign w_l[gi+1] = w_r[gi];
      assign w_r[gi+1] = w_l[gi] ^ w_f;
      assign w_c[gi+1] = w_cRot;
      assign w_d[gi+1] = w_dRot;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= c_stIdle;
         r_roundCnt  <= '0;
         r_left      <= '0;
         r_right     <= '0;
         r_c         <= '0;
         r_d         <= '0;
         r_plainText <= '0;
      end else begin
         case (r_state)
            c_stIdle: begin
               if (bus.in_valid) begin
                  {r_left, r_right} <= ipPerm(bus.cipher_text);
                  {r_c, r_d}        <= pc1Perm(bus.key);
                  r_roundCnt        <= '0;
                  r_state           <= c_stRound;
               end
            end
            c_stRound: begin
               r_left     <= w_l[UNROLL];
               r_right    <= w_r[UNROLL];
               r_c        <= w_c[UNROLL];
               r_d        <= w_d[UNROLL];
               r_roundCnt <= w_nextCnt;
               // Output is {R16, L16}: the final half swap is undone here.
               if (w_nextCnt == 5'd16) begin
                  r_plainText <= fpPerm({w_r[UNROLL], w_l[UNROLL]});
                  r_state     <= c_stDone;
               end
            end
            c_stDone: begin
               if (bus.out_ready) begin
                  r_state <= c_stIdle;
               end
            end
            default: r_state <= c_stIdle;
         endcase
      end
   end

   assign bus.in_ready   = (r_state == c_stIdle);
   assign bus.out_valid  = (r_state == c_stDone);
   assign bus.busy       = (r_state == c_stRound);
   assign bus.plain_text = r_plainText;

endmodule
`default_nettype wire
